// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file with two prioritised write ports,
// per-port read bypass and a sequenced bulk-clear engine. Define REGFILE_ZERO_REG_EN to hardwire entry 0 to zero.
module regfile_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_valid,
  input  logic                     wr_en0,
  input  logic [ADDR_W-1:0]        wr_addr0,
  input  logic [DATA_W-1:0]        wr_data0,
  input  logic                     wr_en1,
  input  logic [ADDR_W-1:0]        wr_addr1,
  input  logic [DATA_W-1:0]        wr_data1,
  input  logic                     clr_req,
  output logic                     busy
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] LAST_PTR = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] PTR_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
`ifdef REGFILE_ZERO_REG_EN
  localparam logic ZERO_REG = 1'b1;
`else
  localparam logic ZERO_REG = 1'b0;
`endif

  typedef enum logic [0:0] {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  state_t                   state_r, state_nxt_s;
  logic [ADDR_W:0]          ptr_r, ptr_nxt_s;
  logic [DATA_W-1:0]        mem_r [DEPTH];
  logic                     we0_s, we1_s;
  logic [NUM_RD-1:0]        rd_fire_s;
  logic [NUM_RD*DATA_W-1:0] rd_next_s;
  logic [NUM_RD*DATA_W-1:0] rd_data_r;
  logic [NUM_RD-1:0]        rd_valid_r;
  logic                     busy_r;

  assign rd_data  = rd_data_r;
  assign rd_valid = rd_valid_r;
  assign busy     = busy_r;

  // Effective write enables: port 1 wins an address collision, entry 0 may be read-only.
  always_comb begin
    we0_s = 1'b0;
    we1_s = 1'b0;
    if (state_r == IDLE) begin
      we1_s = wr_en1 && (!ZERO_REG || (wr_addr1 != ADDR_ZERO));
      we0_s = wr_en0 && (!ZERO_REG || (wr_addr0 != ADDR_ZERO)) &&
              !(we1_s && (wr_addr1 == wr_addr0));
    end else begin
      we0_s = 1'b0;
      we1_s = 1'b0;
    end
  end

  // Read launch with same-cycle write forwarding; idle ports hold their last data.
  always_comb begin
    rd_fire_s = {NUM_RD{1'b0}};
    rd_next_s = rd_data_r;
    for (int i = 0; i < NUM_RD; i++) begin
      if ((state_r == IDLE) && rd_en[i]) begin
        rd_fire_s[i] = 1'b1;
        if (we1_s && (wr_addr1 == rd_addr[i*ADDR_W +: ADDR_W])) begin
          rd_next_s[i*DATA_W +: DATA_W] = wr_data1;
        end else if (we0_s && (wr_addr0 == rd_addr[i*ADDR_W +: ADDR_W])) begin
          rd_next_s[i*DATA_W +: DATA_W] = wr_data0;
        end else if (ZERO_REG && (rd_addr[i*ADDR_W +: ADDR_W] == ADDR_ZERO)) begin
          rd_next_s[i*DATA_W +: DATA_W] = {DATA_W{1'b0}};
        end else begin
          rd_next_s[i*DATA_W +: DATA_W] = mem_r[rd_addr[i*ADDR_W +: ADDR_W]];
        end
      end else begin
        rd_fire_s[i] = 1'b0;
      end
    end
  end

  // Clear sequencer next state: one entry per cycle, terminal at DEPTH-1 without wrapping.
  always_comb begin
    state_nxt_s = state_r;
    ptr_nxt_s   = ptr_r;
    case (state_r)
      IDLE: begin
        ptr_nxt_s = {(ADDR_W+1){1'b0}};
        if (clr_req) begin
          state_nxt_s = CLEAR;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      CLEAR: begin
        if (ptr_r == LAST_PTR) begin
          state_nxt_s = IDLE;
          ptr_nxt_s   = {(ADDR_W+1){1'b0}};
        end else begin
          state_nxt_s = CLEAR;
          ptr_nxt_s   = ptr_r + PTR_ONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        ptr_nxt_s   = {(ADDR_W+1){1'b0}};
      end
    endcase
  end

  // Sequencer state, sweep pointer and busy flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      ptr_r   <= {(ADDR_W+1){1'b0}};
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      ptr_r   <= ptr_nxt_s;
      busy_r  <= (state_nxt_s == CLEAR);
    end
  end

  // Storage array: sweep zeroing while clearing, port writes while idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem_r[k] <= {DATA_W{1'b0}};
      end
    end else if (state_r == CLEAR) begin
      mem_r[ptr_r[ADDR_W-1:0]] <= {DATA_W{1'b0}};
    end else begin
      if (we0_s) begin
        mem_r[wr_addr0] <= wr_data0;
      end
      if (we1_s) begin
        mem_r[wr_addr1] <= wr_data1;
      end
    end
  end

  // Registered read data and valid strobes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data_r  <= {(NUM_RD*DATA_W){1'b0}};
      rd_valid_r <= {NUM_RD{1'b0}};
    end else begin
      rd_data_r  <= rd_next_s;
      rd_valid_r <= rd_fire_s;
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed and randomized checks of regfile_mp against an array-level
// model; honours REGFILE_ZERO_REG_EN the same way the design does.
module tb_regfile_mp;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int DEPTH = 32;
`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZREG = 1'b1;
`else
  localparam bit ZREG = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [NR-1:0]    rd_en;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0]    rd_valid;
  logic wr_en0, wr_en1, clr_req, busy;
  logic [AW-1:0] wr_addr0, wr_addr1;
  logic [DW-1:0] wr_data0, wr_data1;

  int vectors = 0;
  int fails = 0;

  logic [DW-1:0] m_mem [DEPTH];
  logic [DW-1:0] m_rd [NR];
  logic [NR-1:0] m_val;
  int m_busy_left;
  int m_ptr;

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_valid(rd_valid), .wr_en0(wr_en0), .wr_addr0(wr_addr0), .wr_data0(wr_data0),
    .wr_en1(wr_en1), .wr_addr1(wr_addr1), .wr_data1(wr_data1), .clr_req(clr_req),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] dout(input int p);
    return rd_data[p*DW +: DW];
  endfunction

  task automatic idle_inputs();
    rd_en = '0; rd_addr = '0; clr_req = 1'b0;
    wr_en0 = 1'b0; wr_addr0 = '0; wr_data0 = '0;
    wr_en1 = 1'b0; wr_addr1 = '0; wr_data1 = '0;
  endtask

  task automatic model_reset();
    for (int k = 0; k < DEPTH; k++) m_mem[k] = '0;
    for (int p = 0; p < NR; p++) m_rd[p] = '0;
    m_val = '0; m_busy_left = 0; m_ptr = 0;
  endtask

  // Apply the current inputs to the model, then advance the DUT one clock.
  task automatic cycle();
    logic [DW-1:0] nxt [DEPTH];
    nxt = m_mem;
    if (m_busy_left > 0) begin
      nxt[m_ptr] = '0; m_ptr++; m_busy_left--; m_val = '0;
    end else begin
      if (wr_en0 && (!ZREG || wr_addr0 != 5'd0)) nxt[wr_addr0] = wr_data0;
      if (wr_en1 && (!ZREG || wr_addr1 != 5'd0)) nxt[wr_addr1] = wr_data1;
      for (int p = 0; p < NR; p++) begin
        logic [AW-1:0] a;
        a = rd_addr[p*AW +: AW];
        m_val[p] = rd_en[p];
        if (rd_en[p]) m_rd[p] = (ZREG && a == 5'd0) ? 32'h0 : nxt[a];
      end
      if (clr_req) begin m_busy_left = DEPTH; m_ptr = 0; end
    end
    m_mem = nxt;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    idle_inputs(); rst = 1'b0; model_reset();
    repeat (2) @(posedge clk); #1;
    vectors++;
    if (rd_data !== '0 || rd_valid !== '0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: got data=%h valid=%b busy=%b, expected all zero", rd_data, rd_valid, busy);
    end
    rst = 1'b1;
    for (int a = 0; a < DEPTH; a++) begin
      rd_en = 2'b11; rd_addr = {5'(DEPTH-1-a), 5'(a)};
      cycle();
      for (int p = 0; p < NR; p++) begin
        vectors++;
        if (dout(p) !== 32'h0 || rd_valid[p] !== 1'b1) begin
          fails++;
          $display("FAIL reset_read a=%0d p=%0d: got %h/%b, expected 00000000/1", a, p, dout(p), rd_valid[p]);
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_bypass();
    idle_inputs();
    wr_en0 = 1'b1; wr_addr0 = 5'd5; wr_data0 = 32'hDEADBEEF;
    rd_en = 2'b01; rd_addr = {5'd0, 5'd5};
    cycle();
    vectors++;
    if (dout(0) !== 32'hDEADBEEF || rd_valid !== 2'b01) begin
      fails++;
      $display("FAIL bypass: got %h valid=%b, expected deadbeef valid=01", dout(0), rd_valid);
    end
    idle_inputs();
    cycle();
    vectors++;
    if (dout(0) !== 32'hDEADBEEF || rd_valid !== 2'b00) begin
      fails++;
      $display("FAIL bypass_hold: got %h valid=%b, expected deadbeef valid=00", dout(0), rd_valid);
    end
    rd_en = 2'b10; rd_addr = {5'd5, 5'd0};
    cycle();
    vectors++;
    if (dout(1) !== 32'hDEADBEEF || rd_valid !== 2'b10) begin
      fails++;
      $display("FAIL bypass_stored: got %h valid=%b, expected deadbeef valid=10", dout(1), rd_valid);
    end
    idle_inputs();
  endtask

  task automatic test_priority();
    idle_inputs();
    wr_en0 = 1'b1; wr_addr0 = 5'd9; wr_data0 = 32'h11111111;
    wr_en1 = 1'b1; wr_addr1 = 5'd9; wr_data1 = 32'h22222222;
    rd_en = 2'b11; rd_addr = {5'd9, 5'd9};
    cycle();
    for (int p = 0; p < NR; p++) begin
      vectors++;
      if (dout(p) !== 32'h22222222) begin
        fails++;
        $display("FAIL prio_bypass p=%0d: got %h, expected 22222222", p, dout(p));
      end
    end
    idle_inputs();
    wr_en0 = 1'b1; wr_addr0 = 5'd3; wr_data0 = 32'hA0A0A0A3;
    wr_en1 = 1'b1; wr_addr1 = 5'd4; wr_data1 = 32'hB0B0B0B4;
    cycle();
    idle_inputs();
    rd_en = 2'b11; rd_addr = {5'd4, 5'd9};
    cycle();
    vectors++;
    if (dout(0) !== 32'h22222222 || dout(1) !== 32'hB0B0B0B4) begin
      fails++;
      $display("FAIL prio_stored: got %h %h, expected 22222222 b0b0b0b4", dout(0), dout(1));
    end
    rd_addr = {5'd3, 5'd3};
    cycle();
    vectors++;
    if (dout(0) !== 32'hA0A0A0A3 || dout(1) !== 32'hA0A0A0A3) begin
      fails++;
      $display("FAIL dual_write: got %h %h, expected a0a0a0a3 twice", dout(0), dout(1));
    end
    idle_inputs();
  endtask

  task automatic test_clear();
    int busy_cnt;
    idle_inputs();
    for (int i = 1; i < DEPTH; i += 2) begin
      wr_en0 = 1'b1; wr_addr0 = 5'(i); wr_data0 = 32'(i*3);
      wr_en1 = (i + 1 < DEPTH); wr_addr1 = 5'(i+1); wr_data1 = 32'((i+1)*3);
      cycle();
    end
    idle_inputs();
    rd_en = 2'b11; rd_addr = {5'd17, 5'd30};
    cycle();
    vectors++;
    if (dout(0) !== 32'd90 || dout(1) !== 32'd51) begin
      fails++;
      $display("FAIL fill_read: got %0d %0d, expected 90 51", dout(0), dout(1));
    end
    idle_inputs();
    clr_req = 1'b1; wr_en1 = 1'b1; wr_addr1 = 5'd7; wr_data1 = 32'h77;
    cycle();
    busy_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (busy !== 1'b1) break;
      busy_cnt++;
      wr_en0 = 1'b1; wr_addr0 = 5'($urandom_range(0, 31)); wr_data0 = $urandom;
      wr_en1 = 1'b1; wr_addr1 = 5'($urandom_range(0, 31)); wr_data1 = $urandom;
      rd_en = 2'b11; rd_addr = 10'($urandom); clr_req = 1'($urandom_range(0, 1));
      cycle();
      vectors++;
      if (rd_valid !== 2'b00 || dout(0) !== m_rd[0] || dout(1) !== m_rd[1]) begin
        fails++;
        $display("FAIL busy_read k=%0d: got valid=%b %h %h, expected 00 %h %h", k, rd_valid, dout(0), dout(1), m_rd[0], m_rd[1]);
      end
    end
    vectors++;
    if (busy_cnt != DEPTH) begin
      fails++;
      $display("FAIL busy_len: got %0d cycles, expected %0d", busy_cnt, DEPTH);
    end
    idle_inputs();
    for (int a = 0; a < DEPTH; a++) begin
      rd_en = 2'b11; rd_addr = {5'(a), 5'(a)};
      cycle();
      vectors++;
      if (rd_data !== '0 || rd_valid !== 2'b11 || busy !== 1'b0) begin
        fails++;
        $display("FAIL post_clear a=%0d: got %h valid=%b busy=%b, expected 0 11 0", a, rd_data, rd_valid, busy);
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_clear();
    idle_inputs();
    wr_en0 = 1'b1; wr_addr0 = 5'd20; wr_data0 = 32'h00001234;
    wr_en1 = 1'b1; wr_addr1 = 5'd25; wr_data1 = 32'h00005678;
    rd_en = 2'b11; rd_addr = {5'd25, 5'd20};
    cycle();
    idle_inputs();
    clr_req = 1'b1;
    cycle();
    idle_inputs();
    repeat (10) cycle();
    rst = 1'b0;
    #1;
    model_reset();
    vectors++;
    if (busy !== 1'b0 || rd_valid !== 2'b00 || rd_data !== '0) begin
      fails++;
      $display("FAIL mid_clear_reset: got busy=%b valid=%b data=%h, expected 0 00 0", busy, rd_valid, rd_data);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    rd_en = 2'b11; rd_addr = {5'd25, 5'd20};
    cycle();
    vectors++;
    if (rd_data !== '0 || rd_valid !== 2'b11 || busy !== 1'b0) begin
      fails++;
      $display("FAIL after_reset_read: got %h valid=%b busy=%b, expected 0 11 0", rd_data, rd_valid, busy);
    end
    idle_inputs();
    wr_en0 = 1'b1; wr_addr0 = 5'd20; wr_data0 = 32'hCAFE0020;
    cycle();
    idle_inputs();
    rd_en = 2'b10; rd_addr = {5'd20, 5'd0};
    cycle();
    vectors++;
    if (dout(1) !== 32'hCAFE0020 || rd_valid !== 2'b10) begin
      fails++;
      $display("FAIL after_reset_write: got %h valid=%b, expected cafe0020 10", dout(1), rd_valid);
    end
    idle_inputs();
  endtask

  task automatic test_zero_reg();
    logic [DW-1:0] exp0;
    exp0 = ZREG ? 32'h0 : 32'hFFFFFFFF;
    idle_inputs();
    wr_en0 = 1'b1; wr_addr0 = 5'd0; wr_data0 = 32'hFFFFFFFF;
    rd_en = 2'b11; rd_addr = {5'd0, 5'd0};
    cycle();
    vectors++;
    if (dout(0) !== exp0 || dout(1) !== exp0) begin
      fails++;
      $display("FAIL zero_bypass: got %h %h, expected %h", dout(0), dout(1), exp0);
    end
    idle_inputs();
    rd_en = 2'b01; rd_addr = {5'd0, 5'd0};
    cycle();
    vectors++;
    if (dout(0) !== exp0) begin
      fails++;
      $display("FAIL zero_stored: got %h, expected %h", dout(0), exp0);
    end
    idle_inputs();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      wr_en0 = 1'($urandom); wr_en1 = 1'($urandom);
      wr_addr0 = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      wr_addr1 = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      wr_data0 = $urandom; wr_data1 = $urandom;
      rd_en = 2'($urandom);
      rd_addr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      clr_req = ($urandom_range(0, 59) == 0);
      cycle();
      vectors++;
      if (busy !== (m_busy_left > 0)) begin
        fails++;
        $display("FAIL rand_busy n=%0d: got %b, expected %b", n, busy, (m_busy_left > 0));
      end
      for (int p = 0; p < NR; p++) begin
        vectors++;
        if (dout(p) !== m_rd[p] || rd_valid[p] !== m_val[p]) begin
          fails++;
          $display("FAIL rand_read n=%0d p=%0d: got %h/%b, expected %h/%b", n, p, dout(p), rd_valid[p], m_rd[p], m_val[p]);
        end
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_bypass();
    test_priority();
    test_clear();
    test_reset_mid_clear();
    test_zero_reg();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
